// File: rtl/mph_phase_ctrl.sv
// Purpose : one-hot phase-enable rotation sequencer (start / stop / realign) for the Np-phase clock path.
// Latency : first ph_en bit two edges after an accepted start (IDLE->ARM->RUN); outputs are registered.
// Backpressure: none; start/stop/sync are level-sampled per state and never stalled.
//
// Ports
//   clk      in   1    master clock, all state updates on posedge
//   rst      in   1    asynchronous reset, active-high
//   start    in   1    start request, honoured in IDLE only
//   stop     in   1    stop request, honoured in ARM/RUN only
//   sync     in   1    realign-to-phase-0 request, honoured in RUN only
//   n_ph     in   W    active phase count, latched into n_act on an accepted start
//   ph_en    out  Np   registered one-hot phase enable, all-zero when not rotating
//   ph_idx   out  IW   index of the asserted ph_en bit, 0 when not rotating
//   wrap     out  1    high while ph_idx == n_act-1 in RUN/DRAIN
//   running  out  1    high in RUN and DRAIN
//   cfg_err  out  1    sticky: last start was rejected for an illegal n_ph
module mph_phase_ctrl #(
   parameter  int Np           = 4,
   parameter  bit STOP_AT_WRAP = 1'b1,
   localparam int W            = $clog2(Np) + 1,
   localparam int IW           = (Np > 1) ? $clog2(Np) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          sync,
   input  logic [W-1:0]  n_ph,
   output logic [Np-1:0] ph_en,
   output logic [IW-1:0] ph_idx,
   output logic          wrap,
   output logic          running,
   output logic          cfg_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [Np-1:0] EN_BASE = Np'(1);

   state_t        state, state_nxt;
   logic [W-1:0]  n_act, n_act_nxt;
   logic [IW-1:0] idx_nxt;
   logic [IW-1:0] idx_inc;
   logic [Np-1:0] ph_en_nxt;
   logic          cfg_err_nxt;
   logic          at_last;
   logic          n_ph_ok;
   logic          rot_nxt;

   // ph_idx is zero-extended to W bits so it compares directly against n_act-1.
   assign at_last = (W'(ph_idx) == (n_act - W'(1)));
   assign idx_inc = at_last ? '0 : (ph_idx + IW'(1));
   assign n_ph_ok = (n_ph != '0) && (n_ph <= W'(Np));

   // Both decode from registered state only, so they are glitch-free with ph_en.
   assign running = (state == S_RUN) || (state == S_DRAIN);
   assign wrap    = running && at_last;

   always_comb begin
      state_nxt   = state;
      n_act_nxt   = n_act;
      idx_nxt     = ph_idx;
      cfg_err_nxt = cfg_err;

      case (state)
         S_IDLE: begin
            // stop beats start: nothing is latched and cfg_err is left alone
            if (start && !stop) begin
               if (n_ph_ok) begin
                  state_nxt   = S_ARM;
                  n_act_nxt   = n_ph;
                  cfg_err_nxt = 1'b0;
               end else begin
                  cfg_err_nxt = 1'b1;
               end
            end
         end
         S_ARM: begin
            if (stop) begin
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_RUN;
               idx_nxt   = '0;
            end
         end
         S_RUN: begin
            // stop outranks sync; a draining stop keeps the rotation advancing
            if (stop) begin
               if (!STOP_AT_WRAP || at_last) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_DRAIN;
                  idx_nxt   = idx_inc;
               end
            end else if (sync) begin
               idx_nxt = '0;
            end else begin
               idx_nxt = idx_inc;
            end
         end
         S_DRAIN: begin
            if (at_last) begin
               state_nxt = S_IDLE;
            end else begin
               idx_nxt = idx_inc;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Outside the rotating states the index is parked at 0 and all enables drop.
      rot_nxt = (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      if (!rot_nxt) begin
         idx_nxt = '0;
      end
      ph_en_nxt = rot_nxt ? (EN_BASE << idx_nxt) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         n_act   <= W'(Np);
         ph_idx  <= '0;
         ph_en   <= '0;
         cfg_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         n_act   <= n_act_nxt;
         ph_idx  <= idx_nxt;
         ph_en   <= ph_en_nxt;
         cfg_err <= cfg_err_nxt;
      end
   end

   // ph_en must be exactly one-hot while rotating and silent otherwise.
   a_ph_en_onehot : assert property (@(posedge clk) disable iff (rst)
      (running ? $onehot(ph_en) : (ph_en == '0)));

endmodule

// File: tb/tb_mph_phase_ctrl.sv
// Bench for mph_phase_ctrl: two instances (drain-at-wrap and immediate stop) share one stimulus.
module tb_mph_phase_ctrl;

   localparam int NP = 4;
   localparam int W  = $clog2(NP) + 1;
   localparam int IW = $clog2(NP);

   logic          clk = 1'b0;
   logic          rst;
   logic          start, stop, sync;
   logic [W-1:0]  n_ph;
   logic [NP-1:0] en_a, en_b;
   logic [IW-1:0] idx_a, idx_b;
   logic          wrap_a, wrap_b, run_a, run_b, err_a, err_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mph_phase_ctrl #(.Np(NP), .STOP_AT_WRAP(1'b1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .sync(sync), .n_ph(n_ph),
      .ph_en(en_a), .ph_idx(idx_a), .wrap(wrap_a), .running(run_a), .cfg_err(err_a));

   mph_phase_ctrl #(.Np(NP), .STOP_AT_WRAP(1'b0)) dut_b (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .sync(sync), .n_ph(n_ph),
      .ph_en(en_b), .ph_idx(idx_b), .wrap(wrap_b), .running(run_b), .cfg_err(err_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 1'b0; stop = 1'b0; sync = 1'b0; n_ph = '0;
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({en_a, idx_a, wrap_a, run_a, err_a, en_b, idx_b, wrap_b, run_b, err_b} !== '0) begin
         fails++;
         $display("FAIL reset_outputs a=%h/%0d/%b/%b/%b b=%h/%0d/%b/%b/%b want all 0",
                  en_a, idx_a, wrap_a, run_a, err_a, en_b, idx_b, wrap_b, run_b, err_b);
      end
   endtask

   task automatic test_full_rotation();
      logic [NP-1:0] exp_en;
      do_reset();
      n_ph = 3'd4; start = 1'b1;
      tick();
      start = 1'b0;
      tests++;
      if ({en_a, run_a, en_b, run_b} !== '0) begin
         fails++;
         $display("FAIL arm_quiet en_a=%h run_a=%b en_b=%h run_b=%b want 0", en_a, run_a, en_b, run_b);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         exp_en = NP'(1) << (i % 4);
         tests++;
         if ({en_a, wrap_a, run_a} !== {exp_en, (i % 4) == 3, 1'b1} ||
             {en_b, wrap_b, run_b} !== {exp_en, (i % 4) == 3, 1'b1}) begin
            fails++;
            $display("FAIL rot4 cyc%0d a=%h/%b/%b b=%h/%b/%b want en=%h wrap=%b run=1",
                     i, en_a, wrap_a, run_a, en_b, wrap_b, run_b, exp_en, (i % 4) == 3);
         end
      end
   endtask

   task automatic test_n3();
      logic [NP-1:0] exp_en;
      do_reset();
      n_ph = 3'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         exp_en = NP'(1) << (i % 3);
         tests++;
         if ({en_a, idx_a, wrap_a} !== {exp_en, IW'(i % 3), (i % 3) == 2} || en_a[3] !== 1'b0) begin
            fails++;
            $display("FAIL rot3 cyc%0d en=%h idx=%0d wrap=%b want en=%h idx=%0d wrap=%b",
                     i, en_a, idx_a, wrap_a, exp_en, i % 3, (i % 3) == 2);
         end
      end
   endtask

   task automatic test_sync();
      do_reset();
      n_ph = 3'd4; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      tests++;
      if (idx_a !== 2'd2) begin
         fails++;
         $display("FAIL sync_pre idx=%0d want 2", idx_a);
      end
      sync = 1'b1;
      tick();
      sync = 1'b0;
      tests++;
      if ({idx_a, en_a, idx_b, en_b} !== {2'd0, 4'h1, 2'd0, 4'h1}) begin
         fails++;
         $display("FAIL sync_realign a=%0d/%h b=%0d/%h want 0/1", idx_a, en_a, idx_b, en_b);
      end
      for (int j = 1; j <= 3; j++) begin
         tick();
         tests++;
         if (idx_a !== IW'(j) || !$onehot(en_a) || en_a !== (NP'(1) << j)) begin
            fails++;
            $display("FAIL sync_post step%0d idx=%0d en=%h want idx=%0d", j, idx_a, en_a, j);
         end
      end
   endtask

   task automatic test_stop();
      do_reset();
      n_ph = 3'd4; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      tests++;
      if ({idx_a, idx_b} !== {2'd1, 2'd1}) begin
         fails++;
         $display("FAIL stop_pre idx_a=%0d idx_b=%0d want 1", idx_a, idx_b);
      end
      // stop together with sync: stop must win on both instances
      stop = 1'b1; sync = 1'b1;
      tick();
      stop = 1'b0; sync = 1'b0;
      tests++;
      if ({run_a, idx_a, en_a} !== {1'b1, 2'd2, 4'h4}) begin
         fails++;
         $display("FAIL drain_step1 run=%b idx=%0d en=%h want 1/2/4", run_a, idx_a, en_a);
      end
      tests++;
      if ({run_b, idx_b, en_b, wrap_b} !== '0) begin
         fails++;
         $display("FAIL stop_now run=%b idx=%0d en=%h wrap=%b want 0", run_b, idx_b, en_b, wrap_b);
      end
      tick();
      tests++;
      if ({run_a, idx_a, en_a, wrap_a} !== {1'b1, 2'd3, 4'h8, 1'b1}) begin
         fails++;
         $display("FAIL drain_step2 run=%b idx=%0d en=%h wrap=%b want 1/3/8/1", run_a, idx_a, en_a, wrap_a);
      end
      tick();
      tests++;
      if ({run_a, idx_a, en_a, wrap_a} !== '0) begin
         fails++;
         $display("FAIL drain_done run=%b idx=%0d en=%h wrap=%b want 0", run_a, idx_a, en_a, wrap_a);
      end
   endtask

   task automatic test_illegal_start();
      do_reset();
      n_ph = 3'd0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tests++;
      if ({err_a, run_a, en_a, err_b, run_b} !== {1'b1, 1'b0, 4'h0, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL err_n0 err=%b run=%b en=%h err_b=%b run_b=%b want 1/0/0", err_a, run_a, en_a, err_b, run_b);
      end
      do_reset();
      n_ph = 3'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tests++;
      if ({err_a, run_a} !== 2'b10) begin
         fails++;
         $display("FAIL err_n5 err=%b run=%b want 1/0", err_a, run_a);
      end
      // legal count but stop also high: no start, error flag untouched
      n_ph = 3'd2; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      tick();
      tests++;
      if ({err_a, run_a} !== 2'b10) begin
         fails++;
         $display("FAIL start_stop err=%b run=%b want 1/0", err_a, run_a);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tests++;
      if ({err_a, err_b} !== 2'b00) begin
         fails++;
         $display("FAIL err_clear err_a=%b err_b=%b want 0", err_a, err_b);
      end
      tick();
      // start and a new n_ph during RUN must be ignored (n_act stays 2)
      n_ph = 3'd3; start = 1'b1;
      tick();
      tests++;
      if ({en_a, idx_a, wrap_a} !== {4'h2, 2'd1, 1'b1}) begin
         fails++;
         $display("FAIL n_act_held en=%h idx=%0d wrap=%b want 2/1/1", en_a, idx_a, wrap_a);
      end
      tick();
      start = 1'b0;
      tests++;
      if ({en_a, idx_a} !== {4'h1, 2'd0}) begin
         fails++;
         $display("FAIL n_act_wrap en=%h idx=%0d want 1/0", en_a, idx_a);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      n_ph = 3'd4; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      tests++;
      if (run_a !== 1'b1) begin
         fails++;
         $display("FAIL ares_pre run=%b want 1", run_a);
      end
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if ({en_a, idx_a, wrap_a, run_a, err_a, en_b, idx_b, wrap_b, run_b, err_b} !== '0) begin
         fails++;
         $display("FAIL ares_mid a=%h/%0d/%b/%b b=%h/%0d/%b/%b want 0",
                  en_a, idx_a, wrap_a, run_a, en_b, idx_b, wrap_b, run_b);
      end
      rst = 1'b0;
   endtask

   // Reference model: a rotation described as a mode plus a phase counter mod n.
   task automatic test_random();
      int            mode [2];   // 0 idle, 1 armed, 2 rotating, 3 finishing rotation
      int            phase [2];
      int            n [2];
      bit            err [2];
      bit            saw, last, exp_run, exp_wrap;
      int            exp_idx;
      logic [NP-1:0] exp_en;
      logic [NP+IW+2:0] got;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         mode[k] = 0; phase[k] = 0; n[k] = NP; err[k] = 1'b0;
      end
      for (int c = 0; c < 3000; c++) begin
         start = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 9) == 0);
         sync  = ($urandom_range(0, 7) == 0);
         n_ph  = W'($urandom_range(0, 7));
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            saw  = (k == 0);
            last = (mode[k] >= 2) && (phase[k] == n[k] - 1);
            case (mode[k])
               0: if (start && !stop) begin
                     if (n_ph >= 1 && n_ph <= NP) begin
                        mode[k] = 1; n[k] = int'(n_ph); err[k] = 1'b0;
                     end else begin
                        err[k] = 1'b1;
                     end
                  end
               1: if (stop) mode[k] = 0;
                  else begin mode[k] = 2; phase[k] = 0; end
               2: if (stop) begin
                     if (!saw || last) mode[k] = 0;
                     else begin mode[k] = 3; phase[k] = (phase[k] + 1) % n[k]; end
                  end else if (sync) phase[k] = 0;
                  else phase[k] = (phase[k] + 1) % n[k];
               default: if (last) mode[k] = 0;
                        else phase[k] = phase[k] + 1;
            endcase
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            exp_run  = (mode[k] >= 2);
            exp_idx  = exp_run ? phase[k] : 0;
            exp_en   = exp_run ? (NP'(1) << exp_idx) : '0;
            exp_wrap = exp_run && (phase[k] == n[k] - 1);
            got = (k == 0) ? {en_a, idx_a, wrap_a, run_a, err_a} : {en_b, idx_b, wrap_b, run_b, err_b};
            tests++;
            if (got !== {exp_en, IW'(exp_idx), exp_wrap, exp_run, err[k]}) begin
               fails++;
               $display("FAIL rand_%0d cyc%0d got en/idx/wrap/run/err=%h want %h/%0d/%b/%b/%b",
                        k, c, got, exp_en, exp_idx, exp_wrap, exp_run, err[k]);
            end
         end
      end
      start = 1'b0; stop = 1'b0; sync = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; sync = 1'b0; n_ph = '0;
      test_reset();
      test_full_rotation();
      test_n3();
      test_sync();
      test_stop();
      test_illegal_start();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
